// File: rtl/reservation_station.sv
// Reservation station: age-ordered collapsing buffer that snoops the CDB and dispatches the oldest ready entry.
// Latency: accept->dispatch 1 cycle; CDB wakeup->dispatch 1 cycle (0 cycles with RS_WAKEUP_BYPASS_EN defined).
// Backpressure: ready_o drops only when full (never from ready_i); a stalled valid_o holds entries in place.

package rs_pkg;
  localparam int NUM_FU       = 4;
  localparam int NUM_PHYS_REG = 64;
  localparam int WORD_SIZE_P  = 32;
  localparam int TAG_W        = $clog2(NUM_PHYS_REG);

  typedef struct packed {
    logic [3:0]             op;
    logic [TAG_W-1:0]       dest_tag;
    logic                   source_1_v;
    logic [TAG_W-1:0]       source_1_tag;
    logic [WORD_SIZE_P-1:0] source_1_data;
    logic                   source_2_v;
    logic [TAG_W-1:0]       source_2_tag;
    logic [WORD_SIZE_P-1:0] source_2_data;
  } issued_instruction_t;
endpackage

module reservation_station
  import rs_pkg::*;
#(
  parameter int rs_entries = 4,
  parameter int fu_id      = 0
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  issued_instruction_t                  instruction_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  output issued_instruction_t                  instruction_o,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  input  logic [NUM_FU-1:0]                    cdb_v,
  input  logic [NUM_FU-1:0][TAG_W-1:0]         cdb_tag,
  input  logic [NUM_FU-1:0][WORD_SIZE_P-1:0]   cdb_data
);

  localparam int CNT_W = $clog2(rs_entries) + 1;
  localparam int IDX_W = $clog2(rs_entries);

  // Resolve any still-missing source against every CDB lane; the descending
  // loop lets the lowest-index matching lane have the final word.
  function automatic issued_instruction_t wake(
    input issued_instruction_t                ins,
    input logic [NUM_FU-1:0]                  v,
    input logic [NUM_FU-1:0][TAG_W-1:0]       tag,
    input logic [NUM_FU-1:0][WORD_SIZE_P-1:0] data
  );
    issued_instruction_t res;
    res = ins;
    for (int l = NUM_FU - 1; l >= 0; l--) begin
      if (!ins.source_1_v && v[l] && (tag[l] == ins.source_1_tag)) begin
        res.source_1_v    = 1'b1;
        res.source_1_data = data[l];
      end
      if (!ins.source_2_v && v[l] && (tag[l] == ins.source_2_tag)) begin
        res.source_2_v    = 1'b1;
        res.source_2_data = data[l];
      end
    end
    return res;
  endfunction

  issued_instruction_t ent_q [rs_entries];
  logic [rs_entries-1:0] vld_q;
  logic [CNT_W-1:0]      count_q;

  // woken/vld_ext carry one extra always-empty slot so the top entry can
  // shift down from "nothing" without an out-of-range index.
  issued_instruction_t woken [rs_entries+1];
  logic [rs_entries:0]   vld_ext;
  issued_instruction_t   in_woken;

  logic [rs_entries-1:0] ready_vec;
  logic [IDX_W-1:0]      sel;
  logic                  accept;
  logic                  dispatch;
  logic [CNT_W-1:0]      wr_idx;

  issued_instruction_t ent_d [rs_entries];
  logic [rs_entries-1:0] vld_d;
  logic [CNT_W-1:0]      count_d;

  assign vld_ext = {1'b0, vld_q};

  // Apply this cycle's CDB broadcasts to every held entry and to the incoming one.
  always_comb begin
    for (int k = 0; k < rs_entries; k++) begin
      woken[k] = wake(ent_q[k], cdb_v, cdb_tag, cdb_data);
    end
    woken[rs_entries] = '0;
    in_woken = wake(instruction_i, cdb_v, cdb_tag, cdb_data);
  end

  // Ready vector and oldest-first select; the default build looks only at registered operands.
  always_comb begin
    ready_vec = '0;
    sel       = '0;
    for (int k = 0; k < rs_entries; k++) begin
`ifdef RS_WAKEUP_BYPASS_EN
      ready_vec[k] = vld_q[k] & woken[k].source_1_v & woken[k].source_2_v;
`else
      ready_vec[k] = vld_q[k] & ent_q[k].source_1_v & ent_q[k].source_2_v;
`endif
    end
    for (int k = rs_entries - 1; k >= 0; k--) begin
      if (ready_vec[k]) sel = IDX_W'(k);
    end
  end

  // Dispatch port: zero when nothing is ready so the FU never sees stale payload.
  always_comb begin
    valid_o       = |ready_vec;
    instruction_o = '0;
    if (valid_o) begin
`ifdef RS_WAKEUP_BYPASS_EN
      instruction_o = woken[sel];
`else
      instruction_o = ent_q[sel];
`endif
    end
  end

  assign ready_o  = (count_q < CNT_W'(rs_entries)) & ~reset_i;
  assign accept   = valid_i & ready_o;
  assign dispatch = valid_o & ready_i;
  // A same-cycle dispatch frees one slot below the tail, so the newcomer lands one lower.
  assign wr_idx   = count_q - CNT_W'(dispatch);

  // Next buffer contents: collapse above the dispatched slot, then append the newcomer.
  always_comb begin
    for (int k = 0; k < rs_entries; k++) begin
      ent_d[k] = woken[k];
      vld_d[k] = vld_q[k];
      if (dispatch && (k >= int'(sel))) begin
        ent_d[k] = woken[k+1];
        vld_d[k] = vld_ext[k+1];
      end
      if (accept && (wr_idx == CNT_W'(k))) begin
        ent_d[k] = in_woken;
        vld_d[k] = 1'b1;
      end
    end
    count_d = count_q + CNT_W'(accept) - CNT_W'(dispatch);
  end

  // Occupancy state; reset empties the station and overrides same-cycle accept/dispatch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  // Payload storage; contents of invalid slots are don't-care, so no reset is needed.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < rs_entries; k++) begin
      ent_q[k] <= ent_d[k];
    end
  end

  // Sanity checks on configuration, occupancy and CDB consistency.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (rs_entries >= 2);
      assert ((fu_id >= 0) && (fu_id < NUM_FU));
      assert (count_q <= CNT_W'(rs_entries));
      for (int l = 0; l < NUM_FU; l++) begin
        for (int m = l + 1; m < NUM_FU; m++) begin
          if (cdb_v[l] && cdb_v[m] && (cdb_tag[l] == cdb_tag[m])) begin
            assert (cdb_data[l] == cdb_data[m]);
          end
        end
      end
    end
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Per-functional-unit reservation station at the receiving end of the issue-table → reservation-station interface. Accepts issued instructions over a valid/ready handshake and holds them in an age-ordered, collapsing buffer. Snoops all CDB lanes to capture missing source operands, then dispatches the oldest fully-ready entry to its functional unit over a second valid/ready handshake. One instance per FU; `valid_i` is driven by that FU's bit of the issue table's per-FU valid vector, and `ready_o` drives the matching ready bit.

## Interface
- `rs_entries`, default 4: buffer depth; must be ≥ 2.
- `fu_id`, default 0: FU index this station serves, 0..NUM_FU-1; used only for assertions.
- `clk_i`  in  1  clock
- `reset_i`  in  1  synchronous, active-high reset
- `instruction_i`  in  issued_instruction_t  instruction from the issue table
- `valid_i`  in  1  instruction_i valid
- `ready_o`  out  1  station can accept this cycle
- `instruction_o`  out  issued_instruction_t  instruction to the FU, both sources resolved
- `valid_o`  out  1  instruction_o valid
- `ready_i`  in  1  FU accepts this cycle
- `cdb_v`  in  NUM_FU  per-lane broadcast valid
- `cdb_tag`  in  NUM_FU×$clog2(NUM_PHYS_REG)  per-lane destination tag
- `cdb_data`  in  NUM_FU×WORD_SIZE_P  per-lane result

## Operation
- Entry state: `issued_instruction_t` plus a valid bit. Fields used:
  - `source_1_v`, `source_1_tag`, `source_1_data`
  - `source_2_v`, `source_2_tag`, `source_2_data`
- Index 0 holds the oldest entry. Valid entries are always contiguous from index 0.
- **Accept:** occurs when `valid_i & ready_o`. The instruction is written at index `count`, or at `count-1` if a dispatch fires in the same cycle.
- **Ready:** `ready_o = (count < rs_entries) & ~reset_i`. It is independent of `ready_i`, so a full station does not accept in a cycle where it dispatches.
- **Wakeup:**
  - For each valid entry and for the incoming instruction, each source with `_v==0` is compared against every lane with `cdb_v` set.
  - On a tag match, the source latches that lane's `cdb_data` and sets `_v=1` at the clock edge.
  - If several lanes match the same tag, the lowest-index lane wins; the data must be identical, which is asserted.
- **Select:** `ready_vec[k] = valid[k] & src1_v & src2_v`. The lowest ready index is chosen (oldest first).
- **Dispatch:**
  - `valid_o = |ready_vec`; `instruction_o` is the selected entry.
  - When `valid_o & ready_i`, that entry is removed. Entries above it shift down by one, entries below hold, and `count` decrements.
- **Stall:** while `valid_o & ~ready_i`, the choice may change on a later cycle only if an older entry becomes ready. `instruction_o` is not required to stay stable.
- **Counter:** `count` is $clog2(rs_entries)+1 bits wide.
  - accept only: +1
  - dispatch only: −1
  - both: unchanged
- **Reset:** clears all valid bits and `count`, leaving the station empty. Reset overrides any accept or dispatch in the same cycle.

## Timing
- Reset values:
  - `ready_o=0` during reset; `ready_o=1` on the first cycle after reset.
  - `valid_o=0`.
  - `instruction_o='0` when not valid.
- Accept in cycle N → earliest dispatch N+1, if both sources are resolved on entry or resolved by the CDB in cycle N.
- CDB broadcast in cycle N to a held entry → entry dispatchable in N+1 (default build).
- `valid_o` and `instruction_o` depend combinationally on registered state only (default build).
- `ready_o` depends on registered state and reset only; there is no combinational path from `ready_i`.

## Configuration
- `RS_WAKEUP_BYPASS_EN`
  - **Defined:** the ready vector also counts CDB matches from the current cycle. An entry whose last missing source is broadcast in cycle N may dispatch in cycle N, with the CDB data muxed into `instruction_o`. This adds a combinational `cdb_*` → `valid_o`/`instruction_o` path.
  - **Not defined:** wakeup-to-dispatch latency is exactly one cycle, and outputs do not depend on the CDB inputs.

## Test plan
- **Reset and accept:** reset, then `valid_i=1` with both sources resolved, `ready_i=1`.
  - `ready_o` is 0 during reset and 1 after.
  - `valid_o=1` the next cycle, with `instruction_o` equal to the input.
- **Wakeup:** accept an entry with `source_1_v=0`, `source_1_tag=7`. Two cycles later, drive `cdb_v[1]=1`, `cdb_tag[1]=7`, `cdb_data[1]=32'hDEADBEEF`.
  - Expected `source_1_data=32'hDEADBEEF`.
  - Dispatch occurs the following cycle; with `RS_WAKEUP_BYPASS_EN` it occurs the same cycle.
- **Entry-cycle capture:** present an instruction with an unresolved tag 12 while lane 0 broadcasts tag 12 in the same cycle.
  - The entry is stored resolved and dispatches at N+1.
- **Full and ordering:** hold `ready_i=0` and fill 4 entries A–D, with B and D ready and A and C waiting.
  - `ready_o=0` when full.
  - Raise `ready_i`: dispatch order is B then D.
  - Waking C then A gives order C, A.
- **Simultaneous accept and dispatch:** at count 2, accept E while dispatching the index-0 entry.
  - count stays 2, E lands at index 1, and no entry is duplicated or lost.
- **Mid-operation reset:** with 3 entries and a pending dispatch, assert `reset_i` for 1 cycle.
  - Next cycle: `valid_o=0`, `ready_o=1`, count 0, and no stale entry is ever dispatched afterward.
